flit_packetizer: RTL

Packet-to-flit source stage that sits directly upstream of `virtual_channel`. It accepts a packet descriptor (destination, payload length) and a payload word stream, and emits a HEADER / BODY… / TAIL flit sequence on a FIFO-style write port. That port connects to the virtual channel's `data_i` / `wr_en_i`, and the virtual channel's `rdy_o` is the backpressure input.

---
 rtl/flit_packetizer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/flit_packetizer.sv
// flit_packetizer: turns a packet descriptor (destination, payload length)
// plus a payload word stream into a HEADER / BODY... / TAIL flit sequence
// on a FIFO-style write port feeding a virtual channel.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   pkt_vld_i / pkt_rdy_o   descriptor handshake (dst_i, len_i)
//   pld_i, pld_vld_i        payload word stream, consumed on pld_rdy_o
//   data_o, wr_en_o         flit {ID, data} and its write strobe
//   rdy_i                   downstream not full
//   busy_o                  packet in progress
module flit_packetizer #(
  parameter int unsigned FLIT_DATA_W = 8,
  parameter int unsigned FLIT_ID_W   = 2,
  parameter int unsigned PKT_LEN_W   = 3
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               pkt_vld_i,
  output logic                               pkt_rdy_o,
  input  logic [FLIT_DATA_W-1:0]             dst_i,
  input  logic [PKT_LEN_W-1:0]               len_i,
  input  logic [FLIT_DATA_W-1:0]             pld_i,
  input  logic                               pld_vld_i,
  output logic                               pld_rdy_o,
  output logic [FLIT_DATA_W+FLIT_ID_W-1:0]   data_o,
  output logic                               wr_en_o,
  input  logic                               rdy_i,
  output logic                               busy_o
);

  localparam int unsigned FLIT_W = FLIT_DATA_W + FLIT_ID_W;

  localparam logic [FLIT_ID_W-1:0] ID_HEAD = FLIT_ID_W'(1);
  localparam logic [FLIT_ID_W-1:0] ID_BODY = FLIT_ID_W'(2);
  localparam logic [FLIT_ID_W-1:0] ID_TAIL = FLIT_ID_W'(3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_BODY = 2'd2,
    S_TAIL = 2'd3
  } state_t;

  state_t                 r_state;
  logic [FLIT_DATA_W-1:0] r_dst;
  logic [PKT_LEN_W-1:0]   r_len;
  logic [PKT_LEN_W-1:0]   r_rem;

  logic                   w_pkt_rdy;
  logic                   w_pld_rdy;
  logic                   w_wr_en;
  logic [FLIT_W-1:0]      w_data;

  // Output decode: purely from state/registers plus downstream ready and
  // payload inputs; pkt_vld_i never reaches an output combinationally.
  always_comb begin
    w_pkt_rdy = 1'b0;
    w_pld_rdy = 1'b0;
    w_wr_en   = 1'b0;
    w_data    = '0;
    case (r_state)
      S_IDLE: begin
        // gated so the port reads 0 while reset is held
        w_pkt_rdy = rst_ni;
      end
      S_HEAD: begin
        w_data  = {ID_HEAD, r_dst};
        w_wr_en = rdy_i;
      end
      S_BODY: begin
        w_data    = {ID_BODY, pld_i};
        w_pld_rdy = rdy_i;
        w_wr_en   = rdy_i & pld_vld_i;
      end
      S_TAIL: begin
        if (r_len != '0) begin
          w_data    = {ID_TAIL, pld_i};
          w_pld_rdy = rdy_i;
          w_wr_en   = rdy_i & pld_vld_i;
        end else begin
          // zero-length packet: empty tail, payload stream untouched
          w_data  = {ID_TAIL, FLIT_DATA_W'(0)};
          w_wr_en = rdy_i;
        end
      end
      default: begin
        w_data = '0;
      end
    endcase
  end

  // State, descriptor capture and remaining-word counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_dst   <= '0;
      r_len   <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pkt_vld_i) begin
            r_dst   <= dst_i;
            r_len   <= len_i;
            r_rem   <= len_i;
            r_state <= S_HEAD;
          end
        end
        S_HEAD: begin
          if (w_wr_en) begin
            r_state <= (r_len >= PKT_LEN_W'(2)) ? S_BODY : S_TAIL;
          end
        end
        S_BODY: begin
          if (w_wr_en) begin
            r_rem <= r_rem - PKT_LEN_W'(1);
            // last body flit leaves rem at 1; the tail carries the final word
            if (r_rem == PKT_LEN_W'(2)) begin
              r_state <= S_TAIL;
            end
          end
        end
        S_TAIL: begin
          if (w_wr_en) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pkt_rdy_o = w_pkt_rdy;
  assign pld_rdy_o = w_pld_rdy;
  assign wr_en_o   = w_wr_en;
  assign data_o    = w_data;
  assign busy_o    = (r_state != S_IDLE);

endmodule
